// File: rtl/branch_resolve_unit.sv
// +-----------------------------------------------------------------------+
// | branch_resolve_unit: EX-stage branch check, BTB update and redirect.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             id_valid_i,
  input  logic [31:0]      id_pc_i,
  input  logic             id_pred_taken_i,
  input  logic [31:0]      id_pred_target_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_target_i,
  output logic             upd_valid_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_addr_o,
  output logic [31:0]      upd_target_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               ex_v_q, ex_v_d;
  logic [31:0]        ex_pc_q, ex_pc_d;
  logic               ex_pt_q, ex_pt_d;
  logic [31:0]        ex_ptgt_q, ex_ptgt_d;
  logic               upd_valid_q, upd_valid_d;
  logic               upd_taken_q, upd_taken_d;
  logic [31:0]        upd_addr_q, upd_addr_d;
  logic [31:0]        upd_target_q, upd_target_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic               w_resolve;
  logic [31:0]        w_seq_pc;
  logic [31:0]        w_correct_pc;
  logic [31:0]        w_pred_pc;
  logic               w_alias;
  logic               w_mispredict;

  assign w_resolve    = (state_q == ST_IDLE) && ex_v_q && !stall_i;
  assign w_seq_pc     = ex_pc_q + 32'd4;
  assign w_correct_pc = (ex_is_branch_i && ex_taken_i) ? ex_target_i : w_seq_pc;
  assign w_pred_pc    = ex_pt_q ? ex_ptgt_q : w_seq_pc;
  // A BTB hit on a non-branch is always wrong, whatever target it carried.
  assign w_alias      = !ex_is_branch_i && ex_pt_q;
  assign w_mispredict = w_resolve && (w_alias || (w_correct_pc != w_pred_pc));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (w_mispredict) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ex_v_d    = ex_v_q;
    ex_pc_d   = ex_pc_q;
    ex_pt_d   = ex_pt_q;
    ex_ptgt_d = ex_ptgt_q;
    if (w_mispredict || (state_q == ST_RECOVER)) begin
      ex_v_d = 1'b0;
    end else if (!stall_i) begin
      ex_v_d    = id_valid_i;
      ex_pc_d   = id_pc_i;
      ex_pt_d   = id_pred_taken_i;
      ex_ptgt_d = id_pred_target_i;
    end
  end

  always_comb begin
    upd_valid_d      = 1'b0;
    upd_taken_d      = upd_taken_q;
    upd_addr_d       = upd_addr_q;
    upd_target_d     = upd_target_q;
    redirect_valid_d = w_mispredict;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = w_mispredict;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;
    if (w_resolve && ex_is_branch_i) begin
      upd_valid_d  = 1'b1;
      upd_taken_d  = ex_taken_i;
      upd_addr_d   = ex_pc_q;
      upd_target_d = ex_target_i;
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (w_mispredict) begin
      redirect_pc_d = w_correct_pc;
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ex_v_q           <= 1'b0;
      ex_pc_q          <= 32'd0;
      ex_pt_q          <= 1'b0;
      ex_ptgt_q        <= 32'd0;
      upd_valid_q      <= 1'b0;
      upd_taken_q      <= 1'b0;
      upd_addr_q       <= 32'd0;
      upd_target_q     <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      ex_v_q           <= ex_v_d;
      ex_pc_q          <= ex_pc_d;
      ex_pt_q          <= ex_pt_d;
      ex_ptgt_q        <= ex_ptgt_d;
      upd_valid_q      <= upd_valid_d;
      upd_taken_q      <= upd_taken_d;
      upd_addr_q       <= upd_addr_d;
      upd_target_q     <= upd_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign upd_valid_o        = upd_valid_q;
  assign upd_taken_o        = upd_taken_q;
  assign upd_addr_o         = upd_addr_q;
  assign upd_target_o       = upd_target_q;
  assign redirect_valid_o   = redirect_valid_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign flush_o            = flush_q;
  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// +-----------------------------------------------------------------------+
// | tb_branch_resolve_unit: directed and random checks of the resolver.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, stall, id_valid, id_pred_taken, ex_is_branch, ex_taken;
  logic [31:0] id_pc, id_pred_target, ex_target;
  logic        upd_valid, upd_taken, redirect_valid, flush;
  logic [31:0] upd_addr, upd_target, redirect_pc, branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall),
    .id_valid_i         (id_valid),
    .id_pc_i            (id_pc),
    .id_pred_taken_i    (id_pred_taken),
    .id_pred_target_i   (id_pred_target),
    .ex_is_branch_i     (ex_is_branch),
    .ex_taken_i         (ex_taken),
    .ex_target_i        (ex_target),
    .upd_valid_o        (upd_valid),
    .upd_taken_o        (upd_taken),
    .upd_addr_o         (upd_addr),
    .upd_target_o       (upd_target),
    .redirect_valid_o   (redirect_valid),
    .redirect_pc_o      (redirect_pc),
    .flush_o            (flush),
    .branch_count_o     (branch_count),
    .mispredict_count_o (mispredict_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ins_t;

  // Reference: the instruction waiting in EX, a recovery flag, and expected outputs.
  ins_t        slot[$];
  bit          m_rec;
  logic [31:0] m_bc, m_mc;
  logic        e_uv, e_ut, e_rv, e_fl;
  logic [31:0] e_ua, e_utg, e_rpc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit iv, input logic [31:0] ipc,
                      input bit ipt, input logic [31:0] itgt, input bit eb, input bit et,
                      input logic [31:0] etg);
    bit          mp;
    ins_t        cur;
    logic [31:0] seq, act, prd;
    reset = rst; stall = st; id_valid = iv; id_pc = ipc; id_pred_taken = ipt;
    id_pred_target = itgt; ex_is_branch = eb; ex_taken = et; ex_target = etg;
    mp = 1'b0;
    if (rst) begin
      slot.delete(); m_rec = 0; m_bc = 0; m_mc = 0;
      e_uv = 0; e_ut = 0; e_ua = 0; e_utg = 0; e_rv = 0; e_rpc = 0; e_fl = 0;
    end else begin
      e_uv = 0; e_rv = 0; e_fl = 0;
      if (!m_rec && slot.size() != 0 && !st) begin
        cur = slot[0];
        seq = cur.pc + 32'd4;
        act = (eb && et) ? etg : seq;
        prd = cur.pt ? cur.tgt : seq;
        mp  = (!eb && cur.pt) || (act != prd);
        if (eb) begin e_uv = 1; e_ut = et; e_ua = cur.pc; e_utg = etg; m_bc++; end
        if (mp) begin e_rv = 1; e_fl = 1; e_rpc = act; m_mc++; end
      end
      if (m_rec) begin
        m_rec = 0; slot.delete();
      end else if (mp) begin
        m_rec = 1; slot.delete();
      end else if (!st) begin
        slot.delete();
        if (iv) slot.push_back('{pc: ipc, pt: ipt, tgt: itgt});
      end
    end
    @(posedge clk); #1;
    chk("upd_valid", {31'd0, upd_valid}, {31'd0, e_uv});
    chk("upd_taken", {31'd0, upd_taken}, {31'd0, e_ut});
    chk("upd_addr", upd_addr, e_ua);
    chk("upd_target", upd_target, e_utg);
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("flush", {31'd0, flush}, {31'd0, e_fl});
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
  endtask
  task automatic ld(input logic [31:0] pc, input bit pt, input logic [31:0] tgt);
    step(0, 0, 1, pc, pt, tgt, 0, 0, 32'h0);
  endtask
  task automatic rs(input bit eb, input bit et, input logic [31:0] tgt);
    step(0, 0, 0, 32'h0, 0, 32'h0, eb, et, tgt);
  endtask

  initial begin
    logic [31:0] r, ipc, itgt, etg;
    int          pick;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_flush", {31'd0, flush}, 32'd0);

    // Correct taken prediction
    ld(32'h100, 1, 32'h200);
    rs(1, 1, 32'h200);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t1_upd_addr", upd_addr, 32'h100);
    chk("t1_upd_target", upd_target, 32'h200);
    chk("t1_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t1_bc", branch_count, 32'd1);
    chk("t1_mc", mispredict_count, 32'd0);

    // Predicted taken, actually not taken; wrong-path ID inputs offered
    ld(32'h140, 1, 32'h300);
    step(0, 0, 1, 32'h800, 1, 32'h900, 1, 0, 32'h300);
    chk("t2_redirect_pc", redirect_pc, 32'h144);
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_upd_taken", {31'd0, upd_taken}, 32'd0);
    step(0, 0, 1, 32'h880, 0, 32'h0, 1, 1, 32'h40);
    chk("t2_flush_off", {31'd0, flush}, 32'd0);
    rs(1, 1, 32'h40);
    chk("t2_wrongpath_no_upd", {31'd0, upd_valid}, 32'd0);
    chk("t2_bc", branch_count, 32'd2);

    // Cold BTB
    ld(32'h180, 0, 32'h0);
    rs(1, 1, 32'h80);
    chk("t3_redirect_pc", redirect_pc, 32'h80);
    chk("t3_upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("t3_upd_target", upd_target, 32'h80);
    chk("t3_mc", mispredict_count, 32'd2);
    idle();

    // Alias on a non-branch, then taken to the wrong target
    ld(32'h1C0, 1, 32'h600);
    rs(0, 0, 32'h0);
    chk("t4_alias_pc", redirect_pc, 32'h1C4);
    chk("t4_alias_no_upd", {31'd0, upd_valid}, 32'd0);
    idle();
    ld(32'h200, 1, 32'h500);
    rs(1, 1, 32'h400);
    chk("t4_wrong_tgt_pc", redirect_pc, 32'h400);
    idle();

    // Held resolution under stall, then PC wrap
    ld(32'h240, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 32'h700, 1, 32'h704, 1, 0, 32'h0);
      chk("t5_stalled_no_upd", {31'd0, upd_valid}, 32'd0);
    end
    rs(1, 0, 32'h0);
    chk("t5_upd_after_stall", {31'd0, upd_valid}, 32'd1);
    chk("t5_upd_addr", upd_addr, 32'h240);
    idle();
    chk("t5_single_pulse", {31'd0, upd_valid}, 32'd0);
    ld(32'hFFFF_FFFC, 1, 32'h10);
    rs(1, 0, 32'h0);
    chk("t5_wrap_pc", redirect_pc, 32'h0);
    chk("t5_wrap_rv", {31'd0, redirect_valid}, 32'd1);
    idle();

    // Reset during RECOVER
    ld(32'h300, 1, 32'h10);
    rs(1, 0, 32'h0);
    step(1, 0, 1, 32'h900, 0, 32'h0, 1, 1, 32'h4);
    chk("t6_flush", {31'd0, flush}, 32'd0);
    chk("t6_bc", branch_count, 32'd0);
    chk("t6_mc", mispredict_count, 32'd0);
    ld(32'h340, 1, 32'h380);
    rs(1, 1, 32'h380);
    chk("t6_resolves", {31'd0, upd_valid}, 32'd1);
    chk("t6_bc_after", branch_count, 32'd1);

    // Random traffic against the reference
    for (int n = 0; n < 600; n++) begin
      r    = $urandom;
      ipc  = {r[31:2], 2'b00};
      r    = $urandom;
      itgt = ($urandom_range(0, 3) == 0) ? ipc + 32'd4 : {r[31:2], 2'b00};
      r    = $urandom;
      etg  = {r[31:2], 2'b00};
      if (slot.size() != 0) begin
        pick = $urandom_range(0, 2);
        if (pick == 0) etg = slot[0].tgt;
        else if (pick == 1) etg = slot[0].pc + 32'd4;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 7, ipc, $urandom_range(0, 1) == 1, itgt,
           $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, etg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
